rect_stream_receiver: RTL and testbench

//  GPU-side sink of the rectangle DMA stream. After copy_start, deserializes a gap-free stream of

---
 rtl/rect_stream_receiver.sv | 137 +++++++++++++
 tb/tb_rect_stream_receiver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_stream_receiver.sv
// Sink for the rectangle DMA stream: deserializes 6-word packets into a double-buffered rect table
// and swaps the presented bank only after a frame arrives with every marker word equal to zero.
module rect_stream_receiver #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned RECT_COUNT  = 64,
  localparam int unsigned RIDX_W     = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic [15:0]            data_in,
  input  logic [RIDX_W-1:0]      rd_addr,
  output logic [COORD_WIDTH-1:0] rd_x,
  output logic [COORD_WIDTH-1:0] rd_y,
  output logic [COORD_WIDTH-1:0] rd_width,
  output logic [COORD_WIDTH-1:0] rd_height,
  output logic [15:0]            rd_color,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   disp_bank
);

  localparam int unsigned EntryW = 4 * COORD_WIDTH + 16;
  localparam int unsigned Depth  = 2 ** (RIDX_W + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                 state_q;
  logic [2:0]             word_cnt_q;
  logic [RIDX_W-1:0]      rect_cnt_q;
  logic                   err_sticky_q;
  logic [COORD_WIDTH-1:0] stage_x_q;
  logic [COORD_WIDTH-1:0] stage_y_q;
  logic [COORD_WIDTH-1:0] stage_w_q;
  logic [COORD_WIDTH-1:0] stage_h_q;

  // Bank select is the index MSB; the write bank is always the complement of disp_bank.
  logic [EntryW-1:0] table_mem [Depth];

  logic              last_rect;
  logic              wr_en;
  logic [RIDX_W:0]   wr_idx;
  logic [RIDX_W:0]   rd_idx;
  logic [EntryW-1:0] wr_entry;

  always_comb begin
    last_rect = (rect_cnt_q == RIDX_W'(RECT_COUNT - 1));
    wr_en     = reset && (state_q == StRecv) && (word_cnt_q == 3'd5);
    wr_idx    = {~disp_bank, rect_cnt_q};
    rd_idx    = {disp_bank, rd_addr};
    wr_entry  = {stage_x_q, stage_y_q, stage_w_q, stage_h_q, data_in};
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[wr_idx] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      word_cnt_q   <= 3'd0;
      rect_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      stage_w_q    <= '0;
      stage_h_q    <= '0;
      disp_bank    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
      rd_x         <= '0;
      rd_y         <= '0;
      rd_width     <= '0;
      rd_height    <= '0;
      rd_color     <= '0;
    end else begin
      frame_done <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (copy_start) begin
            state_q    <= StRecv;
            busy       <= 1'b1;
            word_cnt_q <= 3'd0;
            rect_cnt_q <= '0;
          end
        end

        StRecv: begin
          unique case (word_cnt_q)
            3'd0: if (data_in != 16'h0000) err_sticky_q <= 1'b1;
            3'd1: stage_x_q <= data_in[COORD_WIDTH-1:0];
            3'd2: stage_y_q <= data_in[COORD_WIDTH-1:0];
            3'd3: stage_w_q <= data_in[COORD_WIDTH-1:0];
            3'd4: stage_h_q <= data_in[COORD_WIDTH-1:0];
            default: ;
          endcase

          if (word_cnt_q == 3'd5) begin
            word_cnt_q <= 3'd0;
            if (last_rect) begin
              rect_cnt_q <= '0;
              state_q    <= StDone;
              busy       <= 1'b0;
            end else begin
              rect_cnt_q <= rect_cnt_q + RIDX_W'(1);
            end
          end else begin
            word_cnt_q <= word_cnt_q + 3'd1;
          end
        end

        StDone: begin
          // A frame with any nonzero marker is dropped by leaving the display bank in place.
          frame_done   <= 1'b1;
          frame_error  <= err_sticky_q;
          if (!err_sticky_q) disp_bank <= ~disp_bank;
          err_sticky_q <= 1'b0;
          state_q      <= StIdle;
        end

        default: state_q <= StIdle;
      endcase

      rd_x      <= table_mem[rd_idx][EntryW-1 -: COORD_WIDTH];
      rd_y      <= table_mem[rd_idx][EntryW-1-COORD_WIDTH -: COORD_WIDTH];
      rd_width  <= table_mem[rd_idx][EntryW-1-2*COORD_WIDTH -: COORD_WIDTH];
      rd_height <= table_mem[rd_idx][EntryW-1-3*COORD_WIDTH -: COORD_WIDTH];
      rd_color  <= table_mem[rd_idx][15:0];
    end
  end

endmodule

// File: tb/tb_rect_stream_receiver.sv
// Bench for rect_stream_receiver: frame-level stimulus with a read-port scoreboard that predicts
// every registered read from a model of both banks and of the presented bank.
module tb_rect_stream_receiver;

  localparam int NR = 64;
  localparam int NW = 6 * NR;

  logic        clk;
  logic        reset;
  logic        copy_start;
  logic [15:0] data_in;
  logic [5:0]  rd_addr;
  logic [15:0] rd_x, rd_y, rd_width, rd_height, rd_color;
  logic        busy, frame_done, frame_error, disp_bank;

  rect_stream_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .copy_start (copy_start),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_width   (rd_width),
    .rd_height  (rd_height),
    .rd_color   (rd_color),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .disp_bank  (disp_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [79:0] model_tab [2][NR];
  bit          model_vld [2][NR];
  bit          model_disp = 1'b0;
  bit          rand_rd = 1'b1;
  logic [79:0] exp_q [$];

  function automatic logic [15:0] gen_word(input int tag, input int r, input int k,
                                           input int err_rect);
    case (k)
      0:       return (r == err_rect) ? 16'h0001 : 16'h0000;
      1:       return 16'(r + 100 * tag);
      2:       return 16'(2 * r + 100 * tag);
      3:       return 16'(10 + tag);
      4:       return 16'(20 + tag);
      default: return 16'(32'hF000 + r + 256 * tag);
    endcase
  endfunction

  function automatic logic [79:0] gen_entry(input int tag, input int r);
    return {gen_word(tag, r, 1, -1), gen_word(tag, r, 2, -1), gen_word(tag, r, 3, -1),
            gen_word(tag, r, 4, -1), gen_word(tag, r, 5, -1)};
  endfunction

  // One clock: predict the registered read, advance, then score it.
  task automatic cyc();
    bit          pend;
    bit          was_reset;
    logic [79:0] got;
    logic [79:0] want;
    if (rand_rd) rd_addr = 6'($urandom_range(0, NR - 1));
    was_reset = !reset;
    pend = 1'b0;
    if (was_reset) begin
      exp_q.push_back(80'h0);
      pend = 1'b1;
    end else if (model_vld[model_disp][rd_addr]) begin
      exp_q.push_back(model_tab[model_disp][rd_addr]);
      pend = 1'b1;
    end
    @(posedge clk);
    #1;
    if (was_reset) model_disp = 1'b0;
    if (pend) begin
      want = exp_q.pop_front();
      got  = {rd_x, rd_y, rd_width, rd_height, rd_color};
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL rd_data t=%0t got=%h want=%h", $time, got, want);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_bit("idle_busy", busy, 1'b0);
      check_bit("idle_frame_done", frame_done, 1'b0);
    end
  endtask

  // stray_w/abort_w are word indices (edge T+1+w); -1 disables.
  task automatic run_frame(input int tag, input int err_rect, input int stray_w,
                           input bit cs_done, input int abort_w);
    int  r;
    int  k;
    bit  exp_err;
    copy_start = 1'b1;
    data_in    = 16'hBEEF;
    cyc();
    copy_start = 1'b0;
    check_bit("busy_start", busy, 1'b1);
    for (int w = 0; w < NW; w++) begin
      r = w / 6;
      k = w % 6;
      data_in    = gen_word(tag, r, k, err_rect);
      copy_start = (w == stray_w);
      if (w == abort_w) begin
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        copy_start = 1'b0;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_frame_done", frame_done, 1'b0);
        check_bit("abort_disp_bank", disp_bank, 1'b0);
        return;
      end
      cyc();
      if (k == 5) begin
        model_tab[~model_disp][r] = gen_entry(tag, r);
        model_vld[~model_disp][r] = 1'b1;
      end
      check_bit("recv_busy", busy, (w != NW - 1));
      check_bit("recv_frame_done", frame_done, 1'b0);
    end
    copy_start = cs_done;
    data_in    = 16'hDEAD;
    cyc();
    copy_start = 1'b0;
    exp_err = (err_rect >= 0);
    if (!exp_err) model_disp = ~model_disp;
    check_bit("frame_done", frame_done, 1'b1);
    check_bit("frame_error", frame_error, exp_err);
    check_bit("disp_bank", disp_bank, model_disp);
    check_bit("done_busy", busy, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    copy_start = 1'b0;
    data_in = 16'h0;
    rd_addr = 6'd0;
    cyc();
    cyc();
    reset = 1'b1;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check_bit("rst_frame_error", frame_error, 1'b0);
    check_bit("rst_disp_bank", disp_bank, 1'b0);
    idle(3);
  endtask

  task automatic test_single_frame();
    run_frame(0, -1, -1, 1'b0, -1);
    check_bit("f1_disp_is_1", disp_bank, 1'b1);
    rand_rd = 1'b0;
    rd_addr = 6'd5;
    cyc();
    n_checks++;
    if ({rd_x, rd_y, rd_width, rd_height, rd_color} !== {16'd5, 16'd10, 16'd10, 16'd20, 16'hF005})
    begin
      n_errors++;
      $display("FAIL rect5 got=%h %h %h %h %h want=5 a a 14 f005",
               rd_x, rd_y, rd_width, rd_height, rd_color);
    end
    rand_rd = 1'b1;
    idle(2);
  endtask

  task automatic test_error_frame();
    run_frame(1, 17, -1, 1'b0, -1);
    check_bit("err_disp_kept", disp_bank, 1'b1);
    rand_rd = 1'b0;
    rd_addr = 6'd17;
    cyc();
    n_checks++;
    if ({rd_x, rd_y, rd_width, rd_height, rd_color} !== {16'd17, 16'd34, 16'd10, 16'd20, 16'hF011})
    begin
      n_errors++;
      $display("FAIL rect17_old got=%h %h %h %h %h want=11 22 a 14 f011",
               rd_x, rd_y, rd_width, rd_height, rd_color);
    end
    rand_rd = 1'b1;
    idle(4);
    check_bit("frame_error_held", frame_error, 1'b1);
  endtask

  task automatic test_read_during_frame();
    run_frame(2, -1, -1, 1'b0, -1);
    idle(2);
    check_bit("frame_error_cleared", frame_error, 1'b0);
  endtask

  task automatic test_stray_start();
    run_frame(3, -1, 99, 1'b1, -1);
    idle(3);
  endtask

  task automatic test_abort();
    run_frame(6, -1, -1, 1'b0, 199);
    idle(5);
    run_frame(7, -1, -1, 1'b0, -1);
    check_bit("post_abort_disp_is_1", disp_bank, 1'b1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    bit start_bank;
    start_bank = disp_bank;
    run_frame(4, -1, -1, 1'b0, -1);
    run_frame(5, -1, -1, 1'b0, -1);
    check_bit("b2b_two_toggles", disp_bank, start_bank);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_error_frame();
    test_read_during_frame();
    test_stray_start();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
